// File: rtl/bldc_commutator.sv
// Hall-sensor commutation for the eBike BLDC drive: sync + glitch filter on the halls,
// six-step phase selects with commutation blanking, fault flag, period measurement and duty word.
module bldc_commutator #(
    parameter int                MAG_W      = 12,
    parameter int                DUTY_W     = 11,
    parameter logic [DUTY_W-1:0] BRAKE_DUTY = 11'h600,
    parameter int                FILT_CNT   = 2,
    parameter int                BLANK_CYC  = 8,
    parameter int                PER_W      = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MAG_W-1:0]  drv_mag,
    input  logic              hallGrn,
    input  logic              hallYlw,
    input  logic              hallBlu,
    input  logic              brake_n,
    input  logic              dir,
    input  logic              PWM_synch,
    output logic [DUTY_W-1:0] duty,
    output logic [1:0]        selGrn,
    output logic [1:0]        selYlw,
    output logic [1:0]        selBlu,
    output logic              hall_fault,
    output logic [PER_W-1:0]  comm_period,
    output logic              period_vld
);

    localparam int                 BLANK_W    = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
    localparam logic [3:0]         FILT_MAX   = 4'(FILT_CNT);
    localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYC);
    localparam logic [DUTY_W-1:0]  DUTY_MID   = {1'b1, {(DUTY_W-1){1'b0}}};

    function automatic logic isLegal(input logic [2:0] code);
        return (code != 3'b000) && (code != 3'b111);
    endfunction

    // Selects packed as {Grn,Ylw,Blu}; reverse swaps 10/01 inside every phase pair.
    function automatic logic [5:0] phasePattern(input logic [2:0] code, input logic rev);
        logic [5:0] p;
        case (code)
            3'b101:  p = 6'b10_01_00;
            3'b100:  p = 6'b10_00_01;
            3'b110:  p = 6'b00_10_01;
            3'b010:  p = 6'b01_10_00;
            3'b011:  p = 6'b01_00_10;
            3'b001:  p = 6'b00_01_10;
            default: p = 6'b00_00_00;
        endcase
        if (rev) p = {p[4], p[5], p[2], p[3], p[0], p[1]};
        return p;
    endfunction

    function automatic logic [DUTY_W-1:0] dutyWord(input logic braking, input logic [MAG_W-1:0] mag);
        return braking ? BRAKE_DUTY : {1'b1, mag[MAG_W-1 -: DUTY_W-1]};
    endfunction

    logic [2:0]         hallP0, hallP1;
    logic [2:0]         cand;
    logic [3:0]         filtCnt, nextCnt;
    logic [2:0]         accCode;
    logic               accDone;
    logic [2:0]         lastLegal;
    logic               haveLegal;
    logic               dirQ;
    logic [BLANK_W-1:0] blankCnt;
    logic [PER_W-1:0]   perCnt;
    logic [5:0]         selQ;
    logic               accept, legalAcc, newLegal, perEvt, dirEvt, commEvt;

    always_comb begin
        nextCnt = 4'd1;
        if (hallP1 == cand) nextCnt = (filtCnt == FILT_MAX) ? filtCnt : filtCnt + 4'd1;
        accept   = PWM_synch && (nextCnt == FILT_MAX);
        legalAcc = accept && isLegal(hallP1);
        newLegal = legalAcc && (!haveLegal || (hallP1 != lastLegal));
        perEvt   = newLegal && haveLegal;
        dirEvt   = (dir != dirQ) && accDone && isLegal(accCode);
        commEvt  = newLegal || dirEvt;
    end

    // Stage p0/p1: two-flop synchroniser, then the PWM-rate glitch filter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hallP0    <= 3'b000;
            hallP1    <= 3'b000;
            cand      <= 3'b000;
            filtCnt   <= 4'd0;
            accCode   <= 3'b000;
            accDone   <= 1'b0;
            lastLegal <= 3'b000;
            haveLegal <= 1'b0;
        end else begin
            hallP0 <= {hallGrn, hallYlw, hallBlu};
            hallP1 <= hallP0;
            if (PWM_synch) begin
                cand    <= hallP1;
                filtCnt <= nextCnt;
            end
            if (accept) begin
                accCode <= hallP1;
                accDone <= 1'b1;
            end
            if (legalAcc) begin
                lastLegal <= hallP1;
                haveLegal <= 1'b1;
            end
        end
    end

    // Period counter only restarts on a change of legal code; fault codes leave it running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perCnt      <= '0;
            comm_period <= '0;
            period_vld  <= 1'b0;
        end else begin
            if (newLegal)     perCnt <= PER_W'(1);
            else if (~&perCnt) perCnt <= perCnt + PER_W'(1);
            if (perEvt) comm_period <= perCnt;
            period_vld <= perEvt;
        end
    end

    // Braking wins over blanking and fault, and holds the blank counter cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirQ     <= 1'b0;
            blankCnt <= '0;
            selQ     <= 6'b00_00_00;
        end else begin
            dirQ <= dir;
            if (!brake_n)             blankCnt <= '0;
            else if (commEvt)         blankCnt <= BLANK_LOAD;
            else if (blankCnt != '0)  blankCnt <= blankCnt - BLANK_W'(1);
            if (!brake_n)             selQ <= 6'b11_11_11;
            else if (blankCnt != '0)  selQ <= 6'b00_00_00;
            else                      selQ <= phasePattern(accCode, dirQ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         duty <= DUTY_MID;
        else if (PWM_synch) duty <= dutyWord(!brake_n, drv_mag);
    end

    assign {selGrn, selYlw, selBlu} = selQ;
    assign hall_fault = accDone && !isLegal(accCode);

endmodule

// File: tb/tb_bldc_commutator.sv
// Scoreboard bench for bldc_commutator: a reference model predicts every post-edge output,
// a monitor on the falling edge pops and compares.
module tb_bldc_commutator;

    localparam int                MAG_W      = 12;
    localparam int                DUTY_W     = 11;
    localparam logic [DUTY_W-1:0] BRAKE_DUTY = 11'h600;
    localparam int                FILT_CNT   = 2;
    localparam int                BLANK_CYC  = 8;
    localparam int                PER_W      = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [MAG_W-1:0]  drv_mag;
    logic              hallGrn, hallYlw, hallBlu;
    logic              brake_n, dir, PWM_synch;
    logic [DUTY_W-1:0] duty;
    logic [1:0]        selGrn, selYlw, selBlu;
    logic              hall_fault;
    logic [PER_W-1:0]  comm_period;
    logic              period_vld;

    bldc_commutator #(
        .MAG_W(MAG_W), .DUTY_W(DUTY_W), .BRAKE_DUTY(BRAKE_DUTY),
        .FILT_CNT(FILT_CNT), .BLANK_CYC(BLANK_CYC), .PER_W(PER_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .drv_mag(drv_mag),
        .hallGrn(hallGrn), .hallYlw(hallYlw), .hallBlu(hallBlu),
        .brake_n(brake_n), .dir(dir), .PWM_synch(PWM_synch),
        .duty(duty), .selGrn(selGrn), .selYlw(selYlw), .selBlu(selBlu),
        .hall_fault(hall_fault), .comm_period(comm_period), .period_vld(period_vld)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]        sel;
        logic [DUTY_W-1:0] duty;
        logic              fault;
        logic              vld;
        logic [PER_W-1:0]  per;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    function automatic logic legal(input logic [2:0] code);
        return (code != 3'd0) && (code != 3'd7);
    endfunction

    // Phase index 0=Grn 1=Ylw 2=Blu; f sources forward current, r returns it.
    function automatic logic [5:0] drive(input logic [2:0] code, input logic rev);
        int f, r, t;
        logic [1:0] s [3];
        case (code)
            3'd5: begin f = 0; r = 1; end
            3'd4: begin f = 0; r = 2; end
            3'd6: begin f = 1; r = 2; end
            3'd2: begin f = 1; r = 0; end
            3'd3: begin f = 2; r = 0; end
            3'd1: begin f = 2; r = 1; end
            default: return 6'd0;
        endcase
        if (rev) begin t = f; f = r; r = t; end
        for (int p = 0; p < 3; p++) s[p] = (p == f) ? 2'b10 : ((p == r) ? 2'b01 : 2'b00);
        return {s[0], s[1], s[2]};
    endfunction

    // Reference model state: edge-indexed history rather than counters.
    logic [2:0]        pinHist[$];
    logic [2:0]        pwmSamples[$];
    logic [2:0]        mAcc, mLastLegal;
    logic              mAccDone, mHaveLegal, mDirPrev;
    int                mLastEdge, edgeN, mBlankEnd;
    logic [DUTY_W-1:0] mDuty;
    logic [PER_W-1:0]  mPeriod;

    always @(posedge clk) begin : refModel
        logic [2:0] code;
        logic [5:0] expSel;
        logic       dirToggle, commute, vld, acc;
        int         diff;
        if (!rst_n) begin
            pinHist.delete();
            pwmSamples.delete();
            mAcc = 3'd0; mLastLegal = 3'd0; mAccDone = 1'b0; mHaveLegal = 1'b0;
            mDirPrev = 1'b0; mLastEdge = 0; edgeN = 0; mBlankEnd = -1;
            mDuty = 11'h400; mPeriod = '0;
        end else begin
            edgeN++;
            if (!brake_n)              expSel = 6'h3f;
            else if (edgeN <= mBlankEnd) expSel = 6'h00;
            else                       expSel = drive(mAcc, mDirPrev);
            code = (pinHist.size() >= 2) ? pinHist[pinHist.size() - 2] : 3'd0;
            pinHist.push_back({hallGrn, hallYlw, hallBlu});
            if (pinHist.size() > 2) void'(pinHist.pop_front());
            dirToggle = (dir != mDirPrev) && mAccDone && legal(mAcc);
            commute = 1'b0;
            vld     = 1'b0;
            if (PWM_synch) begin
                pwmSamples.push_back(code);
                if (pwmSamples.size() > FILT_CNT) void'(pwmSamples.pop_front());
                acc = (pwmSamples.size() == FILT_CNT);
                for (int i = 0; i < pwmSamples.size(); i++)
                    if (pwmSamples[i] != code) acc = 1'b0;
                if (acc) begin
                    if (legal(code) && (!mHaveLegal || code != mLastLegal)) begin
                        commute = 1'b1;
                        if (mHaveLegal) begin
                            vld  = 1'b1;
                            diff = edgeN - mLastEdge;
                            mPeriod = (diff > (1 << PER_W) - 1) ? '1 : PER_W'(diff);
                        end
                        mLastEdge = edgeN;
                    end
                    if (legal(code)) begin
                        mLastLegal = code;
                        mHaveLegal = 1'b1;
                    end
                    mAcc = code;
                    mAccDone = 1'b1;
                end
                mDuty = brake_n ? DUTY_W'(1024 + (int'(drv_mag) >> (MAG_W - (DUTY_W - 1)))) : BRAKE_DUTY;
            end
            if (!brake_n)                mBlankEnd = -1;
            else if (commute || dirToggle) mBlankEnd = edgeN + BLANK_CYC;
            mDirPrev = dir;
            expQ.push_back('{sel: expSel, duty: mDuty, fault: mAccDone && !legal(mAcc),
                             vld: vld, per: mPeriod});
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) expQ.delete();
        else if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check("sel",         32'({selGrn, selYlw, selBlu}), 32'(e.sel));
            check("duty",        32'(duty),        32'(e.duty));
            check("hall_fault",  32'(hall_fault),  32'(e.fault));
            check("period_vld",  32'(period_vld),  32'(e.vld));
            check("comm_period", 32'(comm_period), 32'(e.per));
        end
    end

    int pwmCnt = 0, pwmLo = 4, pwmHi = 4;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (pwmCnt <= 0) begin
                PWM_synch = 1'b1;
                pwmCnt = int'($urandom_range(pwmHi, pwmLo)) - 1;
            end else begin
                PWM_synch = 1'b0;
                pwmCnt--;
            end
        end
    endtask

    task automatic hold(input logic [2:0] c, input int periods);
        {hallGrn, hallYlw, hallBlu} = c;
        step(periods * 4);
    endtask

    task automatic resetChecks(input string tag);
        check({tag, "_duty"},  32'(duty), 32'h400);
        check({tag, "_sel"},   32'({selGrn, selYlw, selBlu}), 32'h0);
        check({tag, "_fault"}, 32'(hall_fault), 32'h0);
        check({tag, "_per"},   32'(comm_period), 32'h0);
        check({tag, "_vld"},   32'(period_vld), 32'h0);
    endtask

    task automatic applyReset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 resetChecks("midrst");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    logic [2:0] seq [6] = '{3'd5, 3'd4, 3'd6, 3'd2, 3'd3, 3'd1};

    initial begin
        int idx;
        rst_n = 1'b0;
        {hallGrn, hallYlw, hallBlu} = 3'd0;
        brake_n = 1'b1; dir = 1'b0; PWM_synch = 1'b0; drv_mag = 12'h800;
        repeat (2) @(posedge clk);
        #1 resetChecks("rst");
        #1 rst_n = 1'b1;

        // forward commutation, glitch, reverse, fault recovery
        hold(3'd5, 6);
        hold(3'd4, 6);
        hold(3'd6, 1);
        hold(3'd4, 5);
        dir = 1'b1;
        hold(3'd6, 6);
        dir = 1'b0;
        step(20);
        hold(3'd7, 5);
        hold(3'd3, 6);

        // brake mid-blank, then full-scale magnitude on release
        {hallGrn, hallYlw, hallBlu} = 3'd1;
        step(11);
        brake_n = 1'b0;
        step(9);
        drv_mag = 12'hFFC;
        brake_n = 1'b1;
        step(14);

        idx = 5;
        pwmLo = 2; pwmHi = 6;
        for (int it = 0; it < 150; it++) begin
            int act;
            act = int'($urandom_range(9, 0));
            drv_mag = MAG_W'($urandom);
            case (act)
                0, 1, 2, 3, 4: begin
                    idx = dir ? (idx + 5) % 6 : (idx + 1) % 6;
                    hold(seq[idx], int'($urandom_range(4, 1)));
                end
                5: hold(seq[$urandom_range(5, 0)], 1);
                6: hold($urandom_range(1, 0) ? 3'd7 : 3'd0, int'($urandom_range(3, 1)));
                7: begin dir = ~dir; step(int'($urandom_range(12, 1))); end
                8: begin
                    brake_n = 1'b0; step(int'($urandom_range(10, 1)));
                    brake_n = 1'b1; step(int'($urandom_range(8, 1)));
                end
                default: step(int'($urandom_range(20, 1)));
            endcase
        end

        // stall longer than the period counter range, then commutate
        pwmLo = 4; pwmHi = 4;
        brake_n = 1'b1; dir = 1'b0;
        hold(3'd3, 4);
        hold(3'd3, 280);
        hold(3'd1, 6);

        // reset during a blanking window
        hold(3'd5, 4);
        {hallGrn, hallYlw, hallBlu} = 3'd4;
        step(13);
        applyReset();
        hold(3'd6, 5);
        hold(3'd2, 5);
        step(4);
        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
